detection_collector: RTL and testbench
======================================

// Module: detection_collector
// PURPOSE
// - Sits directly downstream of the cascade classifier top; consumes its 1-bit per-window result stream.
// - Tracks window position (x, y) and scale index for every result, in classifier raster order.
// - Buffers positive detections in a FIFO as (x, y, scale) records and emits a per-frame summary.
// PARAMETERS
// IMG_WIDTH       45  source image width, pixels
// IMG_HEIGHT      45  source image height, pixels
// FEATURE_WIDTH   25  window width
// FEATURE_HEIGHT  25  window height
// SCALE_NUM       2   number of pyramid scales
// SCALE_Q         320 per-step downscale factor, Q8 (320 = 1.25)
// FIFO_DEPTH      8   detection FIFO entries, power of 2, >=2
// W_CNT           16  width of per-frame detection counter
// PORTS
// clk              in   1        clock
// rst              in   1        async reset, active-high
// result_valid     in   1        classifier result valid
// result_ready     out  1        collector accepts result
// result_data      in   1        1 = window contains object
// det_valid        out  1        detection record valid
// det_ready        in   1        downstream accepts record
// det_x            out  W_X      window left column, scaled space; W_X=$clog2(IMG_WIDTH)
// det_y            out  W_Y      window top row, scaled space; W_Y=$clog2(IMG_HEIGHT)
// det_scale        out  W_S      scale index; W_S=max(1,$clog2(SCALE_NUM))
// frame_done       out  1        1-cycle pulse after last window of last scale
// frame_det_count  out  W_CNT    detections in finished frame; valid with frame_done, held after
// BEHAVIOUR
// - Reset is asynchronous, active-high. All outputs reset to 0 except result_ready, which resets to 1. Counters reset to x=y=s=0. FIFO is emptied.
// - Scaled dims: D_0 = IMG dim; D_{s+1} = floor(D_s*256/SCALE_Q). These are elaboration-time constants.
// - Windows per row at scale s: NX_s = W_s-FEATURE_WIDTH+1. Rows at scale s: NY_s = H_s-FEATURE_HEIGHT+1. Step is 1.
// - A result is accepted on result_valid && result_ready. Each accepted result advances the position counters:
//   - x increments.
//   - At x = NX_s-1: x goes to 0 and y increments.
//   - At y = NY_s-1: y goes to 0 and s increments.
//   - At s = SCALE_NUM-1: s goes to 0 (end of frame).
// - result_ready = !fifo_full, registered state. Results are back-pressured only while the FIFO is full, whether the result is 0 or 1.
// - Accepted result_data=1:
//   - pushes {x,y,s} (values before the advance) into the FIFO;
//   - increments the frame counter, which saturates at 2^W_CNT-1.
// - FIFO output: det_valid = !empty. Record fields are driven from the head entry. Pop on det_valid && det_ready.
//   - Latency from push handshake to det_valid is 1 cycle. There is no bypass.
//   - Simultaneous push and pop keeps the occupancy unchanged. When full, a push cannot occur, because result_ready is low.
//   - Head fields are stable while det_valid && !det_ready.
// - End of frame is the accepted handshake on the last window (x=NX-1, y=NY-1, s=SCALE_NUM-1). On the next cycle:
//   - frame_done pulses for 1 cycle;
//   - frame_det_count loads the final count, including the last result if it was 1;
//   - the internal counter clears to 0.
// - frame_done is independent of FIFO drain. Records from a finished frame can still be pending when the pulse fires.
// - Reset mid-frame discards pending records and the partial count. No frame_done is produced for the aborted frame.
// STRUCTURE
// - Shared package cc_pkg:
//   - function scaled_dim(dim, s, scale_q);
//   - localparam arrays NX[SCALE_NUM], NY[SCALE_NUM];
//   - typedef struct packed det_rec_t {x, y, scale}.
// - Sub-module sync_fifo #(.W_DATA($bits(det_rec_t)), .DEPTH(FIFO_DEPTH)) with valid/ready on both sides and full/empty flags.
// - Top level of this block holds the position counter FSM, the frame counter and the frame_done logic.
// TESTING (defaults: scale 0 = 21x21 = 441 windows; scale 1 = 36x36 dims, 12x12 = 144 windows; 585 per frame)
// - 585 results, all 0, det_ready=1 -> no det_valid; frame_done 1 cycle after 585th handshake; frame_det_count=0.
// - Only result index 22 = 1 -> one record x=1,y=1,scale=0; det_valid 1 cycle after that handshake; frame_det_count=1.
// - Only index 441 = 1, then index 584 = 1 -> records (0,0,1) then (11,11,1); frame_det_count=2.
// - FIFO_DEPTH=4, det_ready=0, all results 1 -> 4 handshakes, then result_ready=0 and holds; release det_ready -> records pop in order (0,0,0),(1,0,0),(2,0,0),(3,0,0); input resumes.
// - Random result_valid/det_ready stalls over 3 frames vs. reference model -> identical record sequence; frame_done every 585 handshakes.
// - Assert rst after 100 results with 3 records pending -> det_valid=0, result_ready=1; next frame starts at (0,0,0); count from 0.

Source files
------------

// File: rtl/cc_pkg.sv
// Shared geometry, record layout and pyramid helpers for the
// detection collector and its FIFO.
package cc_pkg;

    localparam int IMG_WIDTH      = 45;
    localparam int IMG_HEIGHT     = 45;
    localparam int FEATURE_WIDTH  = 25;
    localparam int FEATURE_HEIGHT = 25;
    localparam int SCALE_NUM      = 2;
    localparam int SCALE_Q        = 320;

    localparam int W_X = $clog2(IMG_WIDTH);
    localparam int W_Y = $clog2(IMG_HEIGHT);
    localparam int W_S = (SCALE_NUM > 1) ? $clog2(SCALE_NUM) : 1;
    localparam int W_D = 16;

    typedef logic [SCALE_NUM-1:0][W_D-1:0] dim_arr_t;

    function automatic int scaled_dim(input int dim, input int s,
                                      input int scale_q);
        int d;
        d = dim;
        for (int i = 0; i < s; i++)
            d = (d * 256) / scale_q;
        return d;
    endfunction

    // Window positions per axis at every pyramid level
    function automatic dim_arr_t win_counts(input int dim, input int feat);
        dim_arr_t a;
        a = '0;
        for (int s = 0; s < SCALE_NUM; s++)
            a[s] = W_D'(scaled_dim(dim, s, SCALE_Q) - feat + 1);
        return a;
    endfunction

    localparam dim_arr_t NX = win_counts(IMG_WIDTH, FEATURE_WIDTH);
    localparam dim_arr_t NY = win_counts(IMG_HEIGHT, FEATURE_HEIGHT);

    typedef struct packed {
        logic [W_X-1:0] x;
        logic [W_Y-1:0] y;
        logic [W_S-1:0] scale;
    } det_rec_t;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with registered full/empty flags and
// valid/ready handshakes on both sides; no write-to-read bypass.
module sync_fifo #(
    parameter int W_DATA = 8,
    parameter int DEPTH  = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [W_DATA-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [W_DATA-1:0] out_data,
    output logic              full,
    output logic              empty
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic [W_DATA-1:0] mem [DEPTH];
    logic [AW-1:0]     wr_ptr;
    logic [AW-1:0]     rd_ptr;
    logic [AW:0]       count;
    logic [AW:0]       count_nxt;
    logic              push;
    logic              pop;

    assign in_ready  = !full;
    assign out_valid = !empty;
    assign out_data  = mem[rd_ptr];
    assign push      = in_valid && !full;
    assign pop       = out_valid && out_ready;

    always_comb begin
        count_nxt = count;
        case ({push, pop})
            2'b10:   count_nxt = count + 1'b1;
            2'b01:   count_nxt = count - 1'b1;
            default: count_nxt = count;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            full   <= 1'b0;
            empty  <= 1'b1;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + 1'b1;
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;
            count <= count_nxt;
            full  <= (count_nxt == FULL_CNT);
            empty <= (count_nxt == '0);
        end
    end

    always_ff @(posedge clk) begin
        if (push)
            mem[wr_ptr] <= in_data;
    end

endmodule

// File: rtl/detection_collector.sv
// Follows classifier raster order (x, y, scale), queues positive
// windows as records and reports a per-frame detection count.
module detection_collector
    import cc_pkg::*;
#(
    parameter int FIFO_DEPTH = 8,
    parameter int W_CNT      = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             result_valid,
    output logic             result_ready,
    input  logic             result_data,
    output logic             det_valid,
    input  logic             det_ready,
    output logic [W_X-1:0]   det_x,
    output logic [W_Y-1:0]   det_y,
    output logic [W_S-1:0]   det_scale,
    output logic             frame_done,
    output logic [W_CNT-1:0] frame_det_count
);

    logic [W_X-1:0]   x;
    logic [W_Y-1:0]   y;
    logic [W_S-1:0]   s;
    logic [W_CNT-1:0] cnt;
    logic [W_CNT-1:0] cnt_inc;
    logic             accept;
    logic             last_x;
    logic             last_y;
    logic             last_s;
    logic             frame_end;
    logic             fifo_full;
    logic             fifo_empty;
    det_rec_t         rec_in;
    det_rec_t         rec_head;
    det_rec_t         rec_out;

    assign accept    = result_valid && result_ready;
    assign last_x    = (W_D'(x) == NX[s] - W_D'(1));
    assign last_y    = (W_D'(y) == NY[s] - W_D'(1));
    assign last_s    = (s == W_S'(SCALE_NUM - 1));
    assign frame_end = accept && last_x && last_y && last_s;

    // Count saturates instead of wrapping on very busy frames
    assign cnt_inc = (accept && result_data && cnt != '1)
                   ? cnt + 1'b1 : cnt;

    assign rec_in.x     = x;
    assign rec_in.y     = y;
    assign rec_in.scale = s;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            x               <= '0;
            y               <= '0;
            s               <= '0;
            cnt             <= '0;
            frame_done      <= 1'b0;
            frame_det_count <= '0;
        end else begin
            frame_done <= frame_end;
            if (frame_end) begin
                frame_det_count <= cnt_inc;
                cnt             <= '0;
            end else begin
                cnt <= cnt_inc;
            end
            if (accept) begin
                if (!last_x) begin
                    x <= x + 1'b1;
                end else begin
                    x <= '0;
                    if (!last_y) begin
                        y <= y + 1'b1;
                    end else begin
                        y <= '0;
                        s <= last_s ? '0 : s + 1'b1;
                    end
                end
            end
        end
    end

    sync_fifo #(
        .W_DATA ($bits(det_rec_t)),
        .DEPTH  (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (result_valid && result_data && !fifo_full),
        .in_ready  (result_ready),
        .in_data   (rec_in),
        .out_valid (det_valid),
        .out_ready (det_ready),
        .out_data  (rec_head),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    // Keep record fields at zero while nothing is queued
    assign rec_out   = fifo_empty ? '0 : rec_head;
    assign det_x     = rec_out.x;
    assign det_y     = rec_out.y;
    assign det_scale = rec_out.scale;

endmodule

// File: tb/tb_detection_collector.sv
// Scoreboard bench for detection_collector: a raster-order model
// predicts records and frame summaries, checked as the DUT emits them.
module tb_detection_collector;
    import cc_pkg::*;

    localparam int FRAME = 585;

    logic             clk = 1'b0;
    logic             rst;
    logic             result_valid;
    logic             result_ready;
    logic             result_data;
    logic             det_valid;
    logic             det_ready;
    logic [W_X-1:0]   det_x;
    logic [W_Y-1:0]   det_y;
    logic [W_S-1:0]   det_scale;
    logic             frame_done;
    logic [15:0]      frame_det_count;

    typedef struct {
        int x;
        int y;
        int s;
    } rec_t;

    rec_t sb[$];
    int   compared   = 0;
    int   mismatched = 0;
    int   mx = 0, my = 0, ms = 0, mcnt = 0;
    bit   done_pend = 1'b0;
    int   done_exp_cnt = 0;
    int   frames_done = 0;
    int   last_count = -1;
    int   ready_mode = 0;

    detection_collector #(
        .FIFO_DEPTH (8),
        .W_CNT      (16)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .result_valid    (result_valid),
        .result_ready    (result_ready),
        .result_data     (result_data),
        .det_valid       (det_valid),
        .det_ready       (det_ready),
        .det_x           (det_x),
        .det_y           (det_y),
        .det_scale       (det_scale),
        .frame_done      (frame_done),
        .frame_det_count (frame_det_count)
    );

    always #5 clk = ~clk;

    initial begin
        det_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            case (ready_mode)
                0:       det_ready = 1'b1;
                1:       det_ready = 1'b0;
                default: det_ready = ($urandom_range(0, 2) != 0);
            endcase
        end
    end

    // Reference model and scoreboard, sampled mid-cycle
    initial begin
        forever begin
            @(negedge clk);
            if (rst) begin
                sb.delete();
                mx = 0; my = 0; ms = 0; mcnt = 0;
                done_pend = 1'b0;
            end else begin
                if (frame_done || done_pend) begin
                    compared++;
                    if (frame_done !== done_pend) begin
                        mismatched++;
                        $display("FAIL frame_done got=%0b exp=%0b t=%0t",
                                 frame_done, done_pend, $time);
                    end
                    if (done_pend) begin
                        compared++;
                        if (frame_det_count !== 16'(done_exp_cnt)) begin
                            mismatched++;
                            $display("FAIL frame_det_count got=%0d exp=%0d",
                                     frame_det_count, done_exp_cnt);
                        end
                        frames_done++;
                        last_count = int'(frame_det_count);
                    end
                    done_pend = 1'b0;
                end
                if (det_valid && det_ready) begin
                    compared++;
                    if (sb.size() == 0) begin
                        mismatched++;
                        $display("FAIL det_record unexpected got=(%0d,%0d,%0d)",
                                 det_x, det_y, det_scale);
                    end else begin
                        rec_t r;
                        r = sb.pop_front();
                        if (det_x !== W_X'(r.x) || det_y !== W_Y'(r.y)
                            || det_scale !== W_S'(r.s)) begin
                            mismatched++;
                            $display("FAIL det_record got=(%0d,%0d,%0d) exp=(%0d,%0d,%0d)",
                                     det_x, det_y, det_scale, r.x, r.y, r.s);
                        end
                    end
                end
                if (result_valid && result_ready) begin
                    int nx;
                    int ny;
                    nx = (ms == 0) ? 21 : 12;
                    ny = (ms == 0) ? 21 : 12;
                    if (result_data) begin
                        sb.push_back('{mx, my, ms});
                        mcnt++;
                    end
                    if (mx == nx-1 && my == ny-1 && ms == 1) begin
                        done_pend = 1'b1;
                        done_exp_cnt = mcnt;
                        mcnt = 0;
                    end
                    if (mx != nx-1) begin
                        mx++;
                    end else begin
                        mx = 0;
                        if (my != ny-1) begin
                            my++;
                        end else begin
                            my = 0;
                            ms = (ms == 1) ? 0 : ms + 1;
                        end
                    end
                end
            end
        end
    end

    task automatic send(input bit d, input bit rnd);
        int n;
        if (rnd) begin
            repeat ($urandom_range(0, 2)) begin
                @(posedge clk);
                #1;
            end
        end
        result_valid = 1'b1;
        result_data  = d;
        n = 0;
        @(negedge clk);
        while (!result_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!result_ready) begin
            compared++;
            mismatched++;
            $display("FAIL send_timeout ready=%0b exp=1", result_ready);
        end
        @(posedge clk);
        #1;
        result_valid = 1'b0;
        result_data  = 1'b0;
    endtask

    task automatic run_frame(input int a, input int b, input bit rnd);
        for (int i = 0; i < FRAME; i++) begin
            if (rnd)
                send($urandom_range(0, 3) == 0, 1'b1);
            else
                send(i == a || i == b, 1'b0);
        end
    endtask

    task automatic settle();
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (sb.size() != 0 && n < 500) begin
            @(posedge clk);
            #1;
            n++;
        end
        compared++;
        if (sb.size() != 0) begin
            mismatched++;
            $display("FAIL drain pending=%0d exp=0", sb.size());
        end
    endtask

    task automatic check_frame(input string name, input int f0, input int cnt);
        compared++;
        if (frames_done != f0 + 1) begin
            mismatched++;
            $display("FAIL %s frames got=%0d exp=%0d", name, frames_done, f0+1);
        end
        compared++;
        if (last_count != cnt) begin
            mismatched++;
            $display("FAIL %s count got=%0d exp=%0d", name, last_count, cnt);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        result_valid = 1'b0;
        result_data  = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        compared++;
        if (det_valid !== 1'b0 || result_ready !== 1'b1 || frame_done !== 1'b0
            || frame_det_count !== 16'd0 || det_x !== '0 || det_y !== '0
            || det_scale !== '0) begin
            mismatched++;
            $display("FAIL reset_state dv=%0b rr=%0b fd=%0b cnt=%0d exp dv=0 rr=1 fd=0 cnt=0",
                     det_valid, result_ready, frame_done, frame_det_count);
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic test_all_zero();
        int f0;
        f0 = frames_done;
        run_frame(-1, -1, 1'b0);
        settle();
        check_frame("all_zero", f0, 0);
    endtask

    task automatic test_single();
        int f0;
        f0 = frames_done;
        for (int i = 0; i < FRAME; i++) begin
            if (i == 22) begin
                result_valid = 1'b1;
                result_data  = 1'b1;
                @(negedge clk);
                compared++;
                if (result_ready !== 1'b1 || det_valid !== 1'b0) begin
                    mismatched++;
                    $display("FAIL no_bypass rr=%0b dv=%0b exp rr=1 dv=0",
                             result_ready, det_valid);
                end
                @(posedge clk);
                #1;
                result_valid = 1'b0;
                result_data  = 1'b0;
                @(negedge clk);
                compared++;
                if (det_valid !== 1'b1 || det_x !== W_X'(1) || det_y !== W_Y'(1)
                    || det_scale !== W_S'(0)) begin
                    mismatched++;
                    $display("FAIL latency dv=%0b rec=(%0d,%0d,%0d) exp dv=1 rec=(1,1,0)",
                             det_valid, det_x, det_y, det_scale);
                end
                @(posedge clk);
                #1;
            end else begin
                send(1'b0, 1'b0);
            end
        end
        settle();
        check_frame("single", f0, 1);
    endtask

    task automatic test_two_scales();
        int f0;
        f0 = frames_done;
        run_frame(441, 584, 1'b0);
        settle();
        check_frame("two_scales", f0, 2);
        drain();
    endtask

    task automatic test_fifo_full();
        int f0;
        int hs;
        f0 = frames_done;
        ready_mode = 1;
        @(posedge clk);
        #1;
        result_valid = 1'b1;
        result_data  = 1'b1;
        hs = 0;
        repeat (12) begin
            @(negedge clk);
            if (result_ready)
                hs++;
            @(posedge clk);
            #1;
        end
        result_valid = 1'b0;
        result_data  = 1'b0;
        compared++;
        if (hs != 8) begin
            mismatched++;
            $display("FAIL full_handshakes got=%0d exp=8", hs);
        end
        repeat (3) @(posedge clk);
        @(negedge clk);
        compared++;
        if (result_ready !== 1'b0 || det_valid !== 1'b1 || det_x !== '0) begin
            mismatched++;
            $display("FAIL full_hold rr=%0b dv=%0b x=%0d exp rr=0 dv=1 x=0",
                     result_ready, det_valid, det_x);
        end
        @(posedge clk);
        #1;
        ready_mode = 0;
        drain();
        compared++;
        if (result_ready !== 1'b1) begin
            mismatched++;
            $display("FAIL resume rr=%0b exp=1", result_ready);
        end
        for (int i = 8; i < FRAME; i++)
            send(1'b0, 1'b0);
        settle();
        check_frame("fifo_full", f0, 8);
    endtask

    task automatic test_random();
        int f0;
        f0 = frames_done;
        ready_mode = 2;
        repeat (3) run_frame(-1, -1, 1'b1);
        settle();
        ready_mode = 0;
        drain();
        compared++;
        if (frames_done != f0 + 3) begin
            mismatched++;
            $display("FAIL random_frames got=%0d exp=%0d", frames_done, f0+3);
        end
    endtask

    task automatic test_reset_mid();
        int f0;
        ready_mode = 1;
        @(posedge clk);
        #1;
        for (int i = 0; i < 100; i++)
            send(i == 10 || i == 50 || i == 90, 1'b0);
        @(negedge clk);
        compared++;
        if (det_valid !== 1'b1) begin
            mismatched++;
            $display("FAIL mid_pending dv=%0b exp=1", det_valid);
        end
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(negedge clk);
        compared++;
        if (det_valid !== 1'b0 || result_ready !== 1'b1
            || frame_det_count !== 16'd0) begin
            mismatched++;
            $display("FAIL mid_reset dv=%0b rr=%0b cnt=%0d exp dv=0 rr=1 cnt=0",
                     det_valid, result_ready, frame_det_count);
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
        ready_mode = 0;
        f0 = frames_done;
        run_frame(0, -1, 1'b0);
        settle();
        check_frame("after_reset", f0, 1);
        drain();
    endtask

    initial begin
        test_reset();
        test_all_zero();
        test_single();
        test_two_scales();
        test_fifo_full();
        test_random();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 compared, mismatched);
        $finish;
    end

endmodule
